sram_rr_ctrl: RTL and testbench

SRAM_RR_CTRL -- requirements
Module: sram_rr_ctrl

---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/sram_rr_ctrl_arb.sv | 17 +
 rtl/sram_rr_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sram_rr_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default widths for the round-robin SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 7;

endpackage

// File: rtl/sram_rr_ctrl_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, ties go to ptr.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_e ptr,
  output logic    gnt_a,
  output logic    gnt_b
);

  always_comb begin
    gnt_a = req_a && (!req_b || (ptr == ID_A));
    gnt_b = req_b && (!req_a || (ptr == ID_B));
  end

endmodule

// File: rtl/sram_rr_ctrl.sv
// Two-requester SRAM controller: optional zero-fill after reset, round-robin
// access to a single-port macro, and tagged routing of read data back.
module sram_rr_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  init_done
);

  localparam state_e                RST_STATE = CLEAR_ON_RESET ? INIT : RUN;
  localparam logic [ADDR_WIDTH:0]   CNT_END   = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic                  init_done_q, init_done_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  req_id_e               ptr_q, ptr_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  rd1_v_q, rd1_v_d;
  req_id_e               rd1_id_q, rd1_id_d;
  logic                  rd2_v_q, rd2_v_d;
  req_id_e               rd2_id_q, rd2_id_d;
  logic                  rvalid_a_q, rvalid_a_d;
  logic                  rvalid_b_q, rvalid_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_WIDTH-1:0] rdata_b_q, rdata_b_d;

  logic arb_gnt_a, arb_gnt_b;
  logic sel_b;
  logic sel_we;

  rr_arb2 u_arb (
    .req_a (req_a),
    .req_b (req_b),
    .ptr   (ptr_q),
    .gnt_a (arb_gnt_a),
    .gnt_b (arb_gnt_b)
  );

  // init_done_q is only set in RUN, so it also keeps grants off during reset
  // and the first post-reset cycle when starting directly in RUN.
  assign gnt_a  = arb_gnt_a && init_done_q;
  assign gnt_b  = arb_gnt_b && init_done_q;
  assign sel_b  = gnt_b;
  assign sel_we = sel_b ? we_b : we_a;

  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    csb_d       = 1'b1;
    web_d       = web_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rd1_v_d     = 1'b0;
    rd1_id_d    = rd1_id_q;
    rd2_v_d     = rd1_v_q;
    rd2_id_d    = rd1_id_q;
    rvalid_a_d  = rd2_v_q && (rd2_id_q == ID_A);
    rvalid_b_d  = rd2_v_q && (rd2_id_q == ID_B);
    rdata_a_d   = rvalid_a_d ? dout0 : rdata_a_q;
    rdata_b_d   = rvalid_b_d ? dout0 : rdata_b_q;

    case (state_q)
      INIT: begin
        // cnt_q reaches CNT_END in the cycle the last zero-write is on the bus
        if (cnt_q == CNT_END) begin
          state_d     = RUN;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end else begin
          csb_d  = 1'b0;
          web_d  = 1'b0;
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          din_d  = '0;
          cnt_d  = cnt_q + (ADDR_WIDTH+1)'(1);
        end
      end
      RUN: begin
        init_done_d = 1'b1;
        if (gnt_a || gnt_b) begin
          csb_d    = 1'b0;
          web_d    = !sel_we;
          addr_d   = sel_b ? addr_b : addr_a;
          din_d    = sel_b ? wdata_b : wdata_a;
          rd1_v_d  = !sel_we;
          rd1_id_d = sel_b ? ID_B : ID_A;
          ptr_d    = sel_b ? ID_A : ID_B;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state_q     <= RST_STATE;
      init_done_q <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= ID_A;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      rd1_v_q     <= 1'b0;
      rd1_id_q    <= ID_A;
      rd2_v_q     <= 1'b0;
      rd2_id_q    <= ID_A;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rd1_v_q     <= rd1_v_d;
      rd1_id_q    <= rd1_id_d;
      rd2_v_q     <= rd2_v_d;
      rd2_id_q    <= rd2_id_d;
      rvalid_a_q  <= rvalid_a_d;
      rvalid_b_q  <= rvalid_b_d;
      rdata_a_q   <= rdata_a_d;
      rdata_b_q   <= rdata_b_d;
    end
  end

  assign csb0      = csb_q;
  assign web0      = web_q;
  assign addr0     = addr_q;
  assign din0      = din_q;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_b  = rvalid_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// Bench for sram_rr_ctrl: SRAM macro model plus a transaction-level reference
// of arbitration, memory contents and response timing.
module tb_sram_rr_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk0  = 1'b0;
  logic          rstb0 = 1'b0;
  logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, csb0, web0, init_done;
  logic [DW-1:0] rdata_a, rdata_b, din0;
  logic [DW-1:0] dout0 = '0;
  logic [AW-1:0] addr0;

  logic          nc_req = 1'b0, nc_we = 1'b0;
  logic [AW-1:0] nc_addr = '0;
  logic [DW-1:0] nc_wdata = '0, nc_dout = '0;
  logic          nc_gnt_a, nc_gnt_b, nc_rvalid_a, nc_rvalid_b, nc_csb0, nc_web0, nc_init_done;
  logic [DW-1:0] nc_rdata_a, nc_rdata_b, nc_din0;
  logic [AW-1:0] nc_addr0;

  always #5 clk0 = ~clk0;

  sram_rr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk0(clk0), .rstb0(rstb0),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .init_done(init_done)
  );

  sram_rr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
    .clk0(clk0), .rstb0(rstb0),
    .req_a(nc_req), .we_a(nc_we), .addr_a(nc_addr), .wdata_a(nc_wdata),
    .gnt_a(nc_gnt_a), .rvalid_a(nc_rvalid_a), .rdata_a(nc_rdata_a),
    .req_b(nc_req), .we_b(nc_we), .addr_b(nc_addr), .wdata_b(nc_wdata),
    .gnt_b(nc_gnt_b), .rvalid_b(nc_rvalid_b), .rdata_b(nc_rdata_b),
    .csb0(nc_csb0), .web0(nc_web0), .addr0(nc_addr0), .din0(nc_din0), .dout0(nc_dout),
    .init_done(nc_init_done)
  );

  // Single-port SRAM macro: active-low chip select and write enable,
  // read data appears after the capturing edge. Contents start as garbage.
  logic [DW-1:0] mem [DEPTH];
  bit            seeded = 1'b0;
  always @(posedge clk0) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
      seeded <= 1'b1;
    end else if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else       dout0      <= mem[addr0];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int            due;
    bit            owner;
    logic [DW-1:0] data;
  } resp_t;

  bit            run_m;
  bit            ptr_m;
  logic [DW-1:0] ref_mem [DEPTH];
  resp_t         pq [$];
  logic [DW-1:0] last_a, last_b;
  bit            bus_v, bus_we;
  logic [AW-1:0] bus_addr, last_addr;
  logic [DW-1:0] bus_din, last_din;
  logic          last_web;
  int            cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    run_m = 1'b0;
    ptr_m = 1'b0;
    pq.delete();
    last_a = '0;
    last_b = '0;
    bus_v  = 1'b0;
  endtask

  // One bus cycle: drive requests, check everything visible this cycle,
  // then advance the reference by whatever transfer the rules allow.
  task automatic step(input bit ra, input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input bit rb, input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    bit    ega, egb, owner, we;
    resp_t r;
    @(negedge clk0);
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    #1;
    ega = 1'b0;
    egb = 1'b0;
    if (run_m) begin
      if (ra && rb) begin
        if (ptr_m) egb = 1'b1;
        else       ega = 1'b1;
      end else begin
        ega = ra;
        egb = rb;
      end
    end
    chk("gnt_a", gnt_a, ega);
    chk("gnt_b", gnt_b, egb);
    chk("init_done", init_done, run_m);

    if (pq.size() > 0 && pq[0].due == cyc) begin
      r = pq.pop_front();
      if (r.owner) last_b = r.data;
      else         last_a = r.data;
      chk("rvalid_a", rvalid_a, !r.owner);
      chk("rvalid_b", rvalid_b, r.owner);
    end else begin
      chk("rvalid_a", rvalid_a, 1'b0);
      chk("rvalid_b", rvalid_b, 1'b0);
    end
    chk("rdata_a", rdata_a, last_a);
    chk("rdata_b", rdata_b, last_b);

    chk("csb0", csb0, !bus_v);
    if (bus_v) begin
      last_web  = !bus_we;
      last_addr = bus_addr;
      last_din  = bus_din;
    end
    chk("web0", web0, last_web);
    chk("addr0", addr0, last_addr);
    chk("din0", din0, last_din);
    chk("nc_csb0", nc_csb0, 1'b1);

    bus_v = 1'b0;
    if (ega || egb) begin
      owner    = egb;
      we       = owner ? wb : wa;
      bus_v    = 1'b1;
      bus_we   = we;
      bus_addr = owner ? ab : aa;
      bus_din  = owner ? db : da;
      if (we) ref_mem[bus_addr] = bus_din;
      else    pq.push_back('{due: cyc + 3, owner: owner, data: ref_mem[bus_addr]});
      ptr_m = !owner;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Asserts reset at the next falling edge, holds it, then releases.
  task automatic do_reset();
    @(negedge clk0);
    rstb0 = 1'b0;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    #1;
    chk("rst_csb0", csb0, 1'b1);
    chk("rst_web0", web0, 1'b1);
    chk("rst_addr0", addr0, '0);
    chk("rst_din0", din0, '0);
    chk("rst_gnt_a", gnt_a, 1'b0);
    chk("rst_gnt_b", gnt_b, 1'b0);
    chk("rst_rvalid_a", rvalid_a, 1'b0);
    chk("rst_rvalid_b", rvalid_b, 1'b0);
    chk("rst_rdata_a", rdata_a, '0);
    chk("rst_rdata_b", rdata_b, '0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_nc_init_done", nc_init_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk0);
      #1;
      chk("rst_hold_rvalid", rvalid_a | rvalid_b, 1'b0);
      chk("rst_hold_csb0", csb0, 1'b1);
    end
    @(negedge clk0);
    rstb0 = 1'b1;
    #1;
    chk("rel_csb0", csb0, 1'b1);
    chk("rel_init_done", init_done, 1'b0);
    model_reset();
  endtask

  // Zero-fill phase: one write of 0 per cycle, ascending, nothing granted.
  task automatic init_check();
    for (int n = 0; n < DEPTH; n++) begin
      @(negedge clk0);
      req_a = 1'($urandom); req_b = 1'($urandom);
      we_a  = 1'($urandom); we_b  = 1'($urandom);
      #1;
      if (n == 0) chk("nc_init_done", nc_init_done, 1'b1);
      chk("init_csb0", csb0, 1'b0);
      chk("init_web0", web0, 1'b0);
      chk("init_addr0", addr0, 32'(n));
      chk("init_din0", din0, '0);
      chk("init_gnt", {gnt_a, gnt_b}, 2'b00);
      chk("init_done_low", init_done, 1'b0);
      chk("init_rvalid", {rvalid_a, rvalid_b}, 2'b00);
      chk("init_nc_csb0", nc_csb0, 1'b1);
    end
    req_a = 1'b0; req_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    run_m     = 1'b1;
    bus_v     = 1'b0;
    last_web  = 1'b0;
    last_addr = AW'(DEPTH - 1);
    last_din  = '0;
  endtask

  initial begin
    do_reset();
    init_check();

    // Freshly cleared memory reads back as zero from either side.
    for (int i = 0; i < 6; i++)
      step(1'($urandom), 0, AW'($urandom), '0, 1'($urandom), 0, AW'($urandom), '0);
    idle(3);

    // Write then read the same address on the next cycle.
    step(1, 1, 7'h10, 8'h5A, 0, 0, '0, '0);
    step(1, 0, 7'h10, 8'h00, 0, 0, '0, '0);
    idle(4);
    chk("wr_rd_rdata_a", rdata_a, 8'h5A);
    chk("wr_rd_rdata_b", rdata_b, '0);

    // Distinct contents, then contending reads to exercise alternation.
    for (int i = 0; i < 6; i++) step(1, 1, AW'(20 + i), DW'(8'hA0 + i), 0, 0, '0, '0);
    for (int i = 0; i < 6; i++) step(1, 0, AW'(20 + i), '0, 1, 0, AW'(25 - i), '0);
    idle(4);

    // Lone requester b, back-to-back reads.
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1, 0, AW'(21 + i), '0);
    idle(4);
    chk("lone_b_last", rdata_b, 8'hA4);

    // Random traffic on a small address window to force hazards.
    for (int i = 0; i < 600; i++)
      step(1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom),
           1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
    idle(4);

    // Reset one cycle after a read grant: the read must vanish.
    step(1, 0, 7'h14, '0, 0, 0, '0, '0);
    do_reset();
    init_check();
    for (int i = 0; i < 20; i++)
      step(1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
           1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
